tage_update_ctrl: RTL and testbench
===================================

# tage_update_ctrl

Training/update controller for the TAGE conditional-branch predictor in the CVA6 frontend. It accepts one resolved-branch record per cycle from the commit/branch-unit side and issues registered write commands to the tagged tables:
- provider counter update
- provider useful-bit update
- new-entry allocation, or useful-bit decay when no entry is free
- periodic useful-bit aging

It also owns the use-alt-on-newly-allocated counter that the lookup side reads.

## Interface
Parameters:
- NTables, 6: number of tagged tables, numbered 1..NTables; provider 0 = bimodal base.
- CtrBits, 3: tagged-table prediction counter width.
- UBits, 2: useful-bit width.
- UResetPeriod, 2048: accepted updates between aging pulses, after the first pulse.
- InitialRstCtr, 1024: updates before the first aging pulse.
- UseAltOnNaBits, 4: use-alt-on-NA counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- upd_valid_i  in  1  update record valid.
- upd_ready_o  out  1  update accepted when valid and ready are both high.
- upd_taken_i  in  1  resolved direction.
- upd_pred_i  in  1  final predicted direction.
- upd_alt_pred_i  in  1  alternate prediction.
- upd_provider_i  in  $clog2(NTables+1)  provider table; 0 = base.
- upd_prov_ctr_i  in  CtrBits  provider counter value at predict time.
- upd_u_i  in  NTables*UBits  u-bits at the indexed entry; slice j-1 = table j.
- prov_upd_valid_o  out  1  provider counter write.
- prov_ctr_o  out  CtrBits  new provider counter.
- prov_u_inc_o / prov_u_dec_o  out  1 each  provider u-bit increment/decrement.
- alloc_valid_o  out  1  allocate an entry.
- alloc_table_o  out  $clog2(NTables+1)  table to allocate in.
- alloc_ctr_o  out  CtrBits  initial counter for the allocated entry.
- dec_u_mask_o  out  NTables  per-table u-bit decrement; bit j-1 = table j.
- u_age_valid_o  out  1  aging pulse to all tables.
- u_age_msb_o  out  1  1 = clear u MSBs; 0 = clear u LSBs.
- use_alt_on_na_o  out  1  MSB of the use-alt-on-NA counter.

## Operation
- State machine: RUN and AGE.
  - RUN: upd_ready_o = 1.
  - AGE: upd_ready_o = 0 and u_age_valid_o = 1. Lasts exactly one cycle, then returns to RUN.
- Per accepted record:
  - mispredict = upd_pred_i != upd_taken_i.
  - p = upd_provider_i.
- Provider counter update (p > 0): prov_ctr_o = upd_prov_ctr_i ± 1 toward upd_taken_i, saturating at 0 and 2^CtrBits-1.
- Provider u-bit update: when p > 0 and upd_pred_i != upd_alt_pred_i:
  - prov_u_inc_o = !mispredict.
  - prov_u_dec_o = mispredict.
- Allocation: when mispredict and p < NTables.
  - Candidates: tables j > p with u == 0.
  - If LFSR bit 0 = 1 and there are at least 2 candidates, allocate in the second-lowest candidate; otherwise allocate in the lowest.
  - alloc_ctr_o = 2^(CtrBits-1) if taken, else 2^(CtrBits-1)-1.
  - If there are no candidates: alloc_valid_o = 0 and dec_u_mask_o has a bit set for every table j > p.
- Use-alt-on-NA counter:
  - Reset value 2^(UseAltOnNaBits-1).
  - Updates when p > 0, upd_prov_ctr_i is weak (2^(CtrBits-1) or 2^(CtrBits-1)-1) and upd_pred_i != upd_alt_pred_i.
  - Increments if upd_alt_pred_i == upd_taken_i, otherwise decrements; saturating in both directions.
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Reset value 16'hACE1.
  - Advances once per accepted record.
- Tick counter:
  - Reset to InitialRstCtr; decrements once per accepted record.
  - When a record decrements it to 0, the next cycle is AGE and the counter reloads to UResetPeriod.
  - u_age_msb_o resets to 1 and toggles after each AGE cycle.

## Timing
- All outputs are registered. A record accepted at edge N drives its write outputs during cycle N+1 for exactly one cycle.
- Back-to-back records are accepted every cycle in RUN.
- An AGE cycle coincides with the write outputs of the record that triggered it. Tables apply those writes first, then the aging.
- Reset values:
  - All valid, inc/dec and mask outputs = 0.
  - upd_ready_o = 1.
  - u_age_msb_o = 1.
  - use_alt_on_na_o = 1.
- Reset asserted during AGE: the state returns to RUN with no further u_age_valid_o pulse, and every counter reinitialises.
- A record with p = NTables that mispredicts produces neither an allocation nor a decay mask.

## Test plan
- Reset check: assert rst_i for 2 cycles. Required: every valid output 0, upd_ready_o = 1, use_alt_on_na_o = 1, no u_age_valid_o pulse afterwards until 1024 records have been accepted.
- Allocation: p = 2, pred = 0, taken = 1, u for tables 3..6 = 1, 0, 0, 0, LFSR bit 0 = 0. Required next cycle: alloc_valid_o = 1, alloc_table_o = 4, alloc_ctr_o = 4.
- No free entry: p = 2, mispredict, all u = 1. Required: alloc_valid_o = 0, dec_u_mask_o = 6'b111100.
- Provider counter saturation:
  - p = 3, ctr = 7, taken = 1, pred = 1, alt = 0: prov_ctr_o = 7 and prov_u_inc_o = 1.
  - p = 3, ctr = 0, taken = 0: prov_ctr_o = 0.
- Aging: stream 1024 valid records back-to-back. Required: u_age_valid_o = 1 with u_age_msb_o = 1 and upd_ready_o = 0 for one cycle. A further 2048 records produce a pulse with u_age_msb_o = 0.
- Use-alt-on-NA: with p = 1 and ctr = 3, apply 9 records where alt is correct and pred is wrong. Required: the counter saturates at 15 and use_alt_on_na_o = 1. Then 8 records where alt is wrong give counter 7 and use_alt_on_na_o = 0.

Source files
------------

// File: rtl/tage_update_ctrl.sv
// ---------------------------------------------------------------------------
// tage_update_ctrl
//
// Training/update controller for the TAGE conditional-branch predictor.
// Takes one resolved-branch record per cycle and turns it into registered
// write commands for the tagged tables:
//   * provider prediction-counter update (saturating, toward the outcome)
//   * provider useful-bit increment/decrement when it disagreed with alt
//   * allocation of a new entry above the provider on a mispredict, or a
//     u-bit decay mask over all higher tables when none is free
//   * periodic u-bit aging (alternating MSB / LSB clear)
// It also owns the use-alt-on-newly-allocated counter read by lookup.
//
// Handshake: a record is transferred on a rising edge where upd_valid_i and
// upd_ready_o are both high. upd_ready_o depends only on internal state (it
// is low only during the single AGE cycle), never on upd_valid_i. The
// producer must hold a record stable until it is transferred.
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   upd_valid_i/ready_o     update record handshake
//   upd_taken_i             resolved direction
//   upd_pred_i              final predicted direction
//   upd_alt_pred_i          alternate prediction
//   upd_provider_i          provider table, 0 = bimodal base
//   upd_prov_ctr_i          provider counter at predict time
//   upd_u_i                 u-bits of the indexed entries, slice j-1 = table j
//   prov_upd_valid_o        provider counter write, value on prov_ctr_o
//   prov_u_inc_o/dec_o      provider u-bit increment / decrement
//   alloc_valid_o           allocate in alloc_table_o with alloc_ctr_o
//   dec_u_mask_o            per-table u-bit decrement, bit j-1 = table j
//   u_age_valid_o           aging pulse to all tables
//   u_age_msb_o             1 = clear u MSBs, 0 = clear u LSBs
//   use_alt_on_na_o         MSB of the use-alt-on-NA counter
//   dbg_state_o             controller state (0 = RUN, 1 = AGE)
// ---------------------------------------------------------------------------
module tage_update_ctrl #(
  parameter int NTables        = 6,
  parameter int CtrBits        = 3,
  parameter int UBits          = 2,
  parameter int UResetPeriod   = 2048,
  parameter int InitialRstCtr  = 1024,
  parameter int UseAltOnNaBits = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         upd_valid_i,
  output logic                         upd_ready_o,
  input  logic                         upd_taken_i,
  input  logic                         upd_pred_i,
  input  logic                         upd_alt_pred_i,
  input  logic [$clog2(NTables+1)-1:0] upd_provider_i,
  input  logic [CtrBits-1:0]           upd_prov_ctr_i,
  input  logic [NTables*UBits-1:0]     upd_u_i,
  output logic                         prov_upd_valid_o,
  output logic [CtrBits-1:0]           prov_ctr_o,
  output logic                         prov_u_inc_o,
  output logic                         prov_u_dec_o,
  output logic                         alloc_valid_o,
  output logic [$clog2(NTables+1)-1:0] alloc_table_o,
  output logic [CtrBits-1:0]           alloc_ctr_o,
  output logic [NTables-1:0]           dec_u_mask_o,
  output logic                         u_age_valid_o,
  output logic                         u_age_msb_o,
  output logic                         use_alt_on_na_o,
  output logic                         dbg_state_o
);

  localparam int PW      = $clog2(NTables+1);
  localparam int TickMax = (InitialRstCtr > UResetPeriod) ? InitialRstCtr : UResetPeriod;
  localparam int TickW   = $clog2(TickMax+1);
  localparam int UaW     = UseAltOnNaBits;

  localparam logic [CtrBits-1:0] CtrMax       = {CtrBits{1'b1}};
  localparam logic [CtrBits-1:0] CtrWeakTaken = CtrBits'(1 << (CtrBits-1));
  localparam logic [CtrBits-1:0] CtrWeakNt    = CtrBits'((1 << (CtrBits-1)) - 1);
  localparam logic [UaW-1:0]     UaInit       = UaW'(1 << (UaW-1));
  localparam logic [UaW-1:0]     UaMax        = {UaW{1'b1}};
  localparam logic [15:0]        LfsrInit     = 16'hACE1;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_AGE = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             r_state;
  logic [TickW-1:0]   r_tick;
  logic               r_age_msb;
  logic [UaW-1:0]     r_use_alt_ctr;
  logic [15:0]        r_lfsr;

  logic               r_prov_upd_valid;
  logic [CtrBits-1:0] r_prov_ctr;
  logic               r_prov_u_inc;
  logic               r_prov_u_dec;
  logic               r_alloc_valid;
  logic [PW-1:0]      r_alloc_table;
  logic [CtrBits-1:0] r_alloc_ctr;
  logic [NTables-1:0] r_dec_u_mask;

  // -------------------------------------------------------------------------
  // Record decode
  // -------------------------------------------------------------------------
  logic               w_accept;
  logic               w_mispredict;
  logic               w_tagged;
  logic               w_u_change;
  logic               w_alloc_req;
  logic [CtrBits-1:0] w_ctr_next;
  logic               w_ctr_weak;
  logic               w_ua_update;
  logic [UaW-1:0]     w_ua_next;
  logic               w_lfsr_fb;

  assign w_accept     = upd_valid_i && (r_state == ST_RUN);
  assign w_mispredict = upd_pred_i != upd_taken_i;
  assign w_tagged     = upd_provider_i != '0;
  assign w_u_change   = w_tagged && (upd_pred_i != upd_alt_pred_i);
  // The highest table has nothing above it to allocate into or decay.
  assign w_alloc_req  = w_mispredict && (int'(upd_provider_i) < NTables);

  always_comb begin
    w_ctr_next = upd_prov_ctr_i;
    if (upd_taken_i) begin
      if (upd_prov_ctr_i != CtrMax) w_ctr_next = upd_prov_ctr_i + CtrBits'(1);
    end else begin
      if (upd_prov_ctr_i != '0) w_ctr_next = upd_prov_ctr_i - CtrBits'(1);
    end
  end

  // A weak provider means the entry is likely freshly allocated; only then
  // does the alt-vs-provider disagreement train the use-alt counter.
  assign w_ctr_weak  = (upd_prov_ctr_i == CtrWeakTaken) || (upd_prov_ctr_i == CtrWeakNt);
  assign w_ua_update = w_tagged && w_ctr_weak && (upd_pred_i != upd_alt_pred_i);

  always_comb begin
    w_ua_next = r_use_alt_ctr;
    if (upd_alt_pred_i == upd_taken_i) begin
      if (r_use_alt_ctr != UaMax) w_ua_next = r_use_alt_ctr + UaW'(1);
    end else begin
      if (r_use_alt_ctr != '0) w_ua_next = r_use_alt_ctr - UaW'(1);
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11 map to bits 0/2/3/5 with a right shift.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // -------------------------------------------------------------------------
  // Allocation candidate search: tables above the provider with u == 0.
  // Keep the lowest and second-lowest so the LFSR can pick between them.
  // -------------------------------------------------------------------------
  logic [NTables-1:0] w_above_mask;
  logic [NTables-1:0] w_cand;
  logic               w_found1;
  logic               w_found2;
  logic [PW-1:0]      w_first;
  logic [PW-1:0]      w_second;
  logic [PW-1:0]      w_alloc_sel;

  always_comb begin
    w_above_mask = '0;
    w_cand       = '0;
    w_found1     = 1'b0;
    w_found2     = 1'b0;
    w_first      = '0;
    w_second     = '0;
    for (int j = 1; j <= NTables; j++) begin
      if (j > int'(upd_provider_i)) begin
        w_above_mask[j-1] = 1'b1;
        if (upd_u_i[(j-1)*UBits +: UBits] == '0) w_cand[j-1] = 1'b1;
      end
    end
    for (int j = 1; j <= NTables; j++) begin
      if (w_cand[j-1]) begin
        if (!w_found1) begin
          w_found1 = 1'b1;
          w_first  = PW'(j);
        end else if (!w_found2) begin
          w_found2 = 1'b1;
          w_second = PW'(j);
        end
      end
    end
  end

  assign w_alloc_sel = (r_lfsr[0] && w_found2) ? w_second : w_first;

  // -------------------------------------------------------------------------
  // Control FSM: RUN accepts records and counts them down; AGE is a single
  // cycle that blocks input while the aging pulse goes out.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_RUN;
      r_tick    <= TickW'(InitialRstCtr);
      r_age_msb <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            if (r_tick == TickW'(1)) begin
              r_state <= ST_AGE;
              r_tick  <= TickW'(UResetPeriod);
            end else begin
              r_tick <= r_tick - TickW'(1);
            end
          end
        end
        ST_AGE: begin
          r_state   <= ST_RUN;
          // Alternate which u-bit half is cleared on the next pulse.
          r_age_msb <= ~r_age_msb;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered write commands, LFSR and use-alt counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prov_upd_valid <= 1'b0;
      r_prov_ctr       <= '0;
      r_prov_u_inc     <= 1'b0;
      r_prov_u_dec     <= 1'b0;
      r_alloc_valid    <= 1'b0;
      r_alloc_table    <= '0;
      r_alloc_ctr      <= '0;
      r_dec_u_mask     <= '0;
      r_use_alt_ctr    <= UaInit;
      r_lfsr           <= LfsrInit;
    end else begin
      r_prov_upd_valid <= w_accept && w_tagged;
      r_prov_u_inc     <= w_accept && w_u_change && !w_mispredict;
      r_prov_u_dec     <= w_accept && w_u_change && w_mispredict;
      r_alloc_valid    <= w_accept && w_alloc_req && w_found1;
      // No free slot above the provider: age every higher entry instead.
      r_dec_u_mask     <= (w_accept && w_alloc_req && !w_found1) ? w_above_mask : '0;
      if (w_accept) begin
        r_prov_ctr    <= w_ctr_next;
        r_alloc_table <= w_alloc_sel;
        r_alloc_ctr   <= upd_taken_i ? CtrWeakTaken : CtrWeakNt;
        r_lfsr        <= {w_lfsr_fb, r_lfsr[15:1]};
        if (w_ua_update) r_use_alt_ctr <= w_ua_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign upd_ready_o      = (r_state == ST_RUN);
  assign u_age_valid_o    = (r_state == ST_AGE);
  assign u_age_msb_o      = r_age_msb;
  assign prov_upd_valid_o = r_prov_upd_valid;
  assign prov_ctr_o       = r_prov_ctr;
  assign prov_u_inc_o     = r_prov_u_inc;
  assign prov_u_dec_o     = r_prov_u_dec;
  assign alloc_valid_o    = r_alloc_valid;
  assign alloc_table_o    = r_alloc_table;
  assign alloc_ctr_o      = r_alloc_ctr;
  assign dec_u_mask_o     = r_dec_u_mask;
  assign use_alt_on_na_o  = r_use_alt_ctr[UaW-1];
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_tage_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tage_update_ctrl
//
// Bench for tage_update_ctrl. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge after the capturing rising edge.
// A behavioural model predicts the outputs of every cycle and pushes them
// into exp_q; a short vector table and hand sequences cover the corners.
// ---------------------------------------------------------------------------
module tb_tage_update_ctrl;

  localparam int NTables        = 6;
  localparam int CtrBits        = 3;
  localparam int UBits          = 2;
  localparam int UResetPeriod   = 2048;
  localparam int InitialRstCtr  = 1024;
  localparam int UseAltOnNaBits = 4;
  localparam int PW             = $clog2(NTables+1);
  localparam int UW             = NTables*UBits;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               upd_valid_i;
  logic               upd_ready_o;
  logic               upd_taken_i;
  logic               upd_pred_i;
  logic               upd_alt_pred_i;
  logic [PW-1:0]      upd_provider_i;
  logic [CtrBits-1:0] upd_prov_ctr_i;
  logic [UW-1:0]      upd_u_i;
  logic               prov_upd_valid_o;
  logic [CtrBits-1:0] prov_ctr_o;
  logic               prov_u_inc_o;
  logic               prov_u_dec_o;
  logic               alloc_valid_o;
  logic [PW-1:0]      alloc_table_o;
  logic [CtrBits-1:0] alloc_ctr_o;
  logic [NTables-1:0] dec_u_mask_o;
  logic               u_age_valid_o;
  logic               u_age_msb_o;
  logic               use_alt_on_na_o;
  logic               dbg_state_o;

  tage_update_ctrl #(
    .NTables(NTables), .CtrBits(CtrBits), .UBits(UBits),
    .UResetPeriod(UResetPeriod), .InitialRstCtr(InitialRstCtr),
    .UseAltOnNaBits(UseAltOnNaBits)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i),
    .upd_alt_pred_i(upd_alt_pred_i), .upd_provider_i(upd_provider_i),
    .upd_prov_ctr_i(upd_prov_ctr_i), .upd_u_i(upd_u_i),
    .prov_upd_valid_o(prov_upd_valid_o), .prov_ctr_o(prov_ctr_o),
    .prov_u_inc_o(prov_u_inc_o), .prov_u_dec_o(prov_u_dec_o),
    .alloc_valid_o(alloc_valid_o), .alloc_table_o(alloc_table_o),
    .alloc_ctr_o(alloc_ctr_o), .dec_u_mask_o(dec_u_mask_o),
    .u_age_valid_o(u_age_valid_o), .u_age_msb_o(u_age_msb_o),
    .use_alt_on_na_o(use_alt_on_na_o), .dbg_state_o(dbg_state_o)
  );

  // -------------------------------------------------------------------------
  // Records
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic               taken;
    logic               pred;
    logic               alt;
    logic [PW-1:0]      prov;
    logic [CtrBits-1:0] ctr;
    logic [UW-1:0]      u;
  } rec_t;

  typedef struct packed {
    logic               ready;
    logic               pv;
    logic [CtrBits-1:0] pctr;
    logic               inc;
    logic               dec;
    logic               av;
    logic [PW-1:0]      at;
    logic [CtrBits-1:0] ac;
    logic [NTables-1:0] mask;
    logic               age;
    logic               msb;
    logic               ua;
  } out_t;

  localparam int OW = $bits(out_t);

  typedef struct {
    rec_t               r;
    logic               pv;
    logic [CtrBits-1:0] pctr;
    logic               inc;
    logic               dec;
    logic               av;
    logic [PW-1:0]      at;
    logic [CtrBits-1:0] ac;
    logic [NTables-1:0] mask;
  } vec_t;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: counts, LFSR and use-alt counter kept as plain integers.
  // -------------------------------------------------------------------------
  int m_lfsr;
  int m_tick;
  bit m_age;
  bit m_msb;
  int m_ua;
  int m_acc;

  task automatic model_reset();
    m_lfsr = 'hACE1;
    m_tick = InitialRstCtr;
    m_age  = 1'b0;
    m_msb  = 1'b1;
    m_ua   = 1 << (UseAltOnNaBits-1);
    m_acc  = 0;
  endtask

  function automatic int u_of(input rec_t r, input int j);
    return int'(r.u[(j-1)*UBits +: UBits]);
  endfunction

  task automatic model_cycle(input bit v, input rec_t r, output out_t e);
    int p;
    int c;
    int half;
    int fb;
    int taps[4];
    bit mis;
    int cand[$];
    e = '0;
    half = 1 << (CtrBits-1);
    if (m_age) begin
      m_age = 1'b0;
      m_msb = !m_msb;
    end else if (v) begin
      p   = int'(r.prov);
      mis = (r.pred != r.taken);
      if (p > 0) begin
        c = int'(r.ctr) + (r.taken ? 1 : -1);
        if (c < 0) c = 0;
        if (c > (1 << CtrBits) - 1) c = (1 << CtrBits) - 1;
        e.pv   = 1'b1;
        e.pctr = CtrBits'(c);
        if (r.pred != r.alt) begin
          e.inc = !mis;
          e.dec = mis;
        end
        if ((int'(r.ctr) == half || int'(r.ctr) == half - 1) && r.pred != r.alt) begin
          m_ua = m_ua + ((r.alt == r.taken) ? 1 : -1);
          if (m_ua < 0) m_ua = 0;
          if (m_ua > (1 << UseAltOnNaBits) - 1) m_ua = (1 << UseAltOnNaBits) - 1;
        end
      end
      if (mis && p < NTables) begin
        for (int j = p + 1; j <= NTables; j++)
          if (u_of(r, j) == 0) cand.push_back(j);
        if (cand.size() == 0) begin
          for (int j = p + 1; j <= NTables; j++) e.mask[j-1] = 1'b1;
        end else begin
          e.av = 1'b1;
          e.at = PW'(((m_lfsr & 1) == 1 && cand.size() >= 2) ? cand[1] : cand[0]);
          e.ac = CtrBits'(r.taken ? half : half - 1);
        end
      end
      taps = '{16, 14, 13, 11};
      fb = 0;
      foreach (taps[k]) fb = fb ^ ((m_lfsr >> (16 - taps[k])) & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
      m_acc++;
      m_tick--;
      if (m_tick == 0) begin
        m_age  = 1'b1;
        m_tick = UResetPeriod;
      end
    end
    e.ready = !m_age;
    e.age   = m_age;
    e.msb   = m_msb;
    e.ua    = (m_ua >= (1 << (UseAltOnNaBits-1)));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on the next falling edge)
  // -------------------------------------------------------------------------
  task automatic check_cycle();
    out_t e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("ready", upd_ready_o, e.ready);
    chk("prov_valid", prov_upd_valid_o, e.pv);
    if (e.pv) chk("prov_ctr", prov_ctr_o, e.pctr);
    chk("u_inc", prov_u_inc_o, e.inc);
    chk("u_dec", prov_u_dec_o, e.dec);
    chk("alloc_valid", alloc_valid_o, e.av);
    if (e.av) begin
      chk("alloc_table", alloc_table_o, e.at);
      chk("alloc_ctr", alloc_ctr_o, e.ac);
    end
    chk("dec_mask", dec_u_mask_o, e.mask);
    chk("age_valid", u_age_valid_o, e.age);
    chk("age_msb", u_age_msb_o, e.msb);
    chk("use_alt", use_alt_on_na_o, e.ua);
  endtask

  task automatic step(input bit v, input rec_t r);
    out_t e;
    check_cycle();
    upd_valid_i    = v;
    upd_taken_i    = r.taken;
    upd_pred_i     = r.pred;
    upd_alt_pred_i = r.alt;
    upd_provider_i = r.prov;
    upd_prov_ctr_i = r.ctr;
    upd_u_i        = r.u;
    model_cycle(v, r, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    out_t e;
    rst         = 1'b1;
    upd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    e = '0;
    e.ready = 1'b1;
    e.msb   = 1'b1;
    e.ua    = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values();
    chk("rst_ready", upd_ready_o, 1);
    chk("rst_prov_valid", prov_upd_valid_o, 0);
    chk("rst_inc_dec", {prov_u_inc_o, prov_u_dec_o}, 0);
    chk("rst_alloc_valid", alloc_valid_o, 0);
    chk("rst_mask", dec_u_mask_o, 0);
    chk("rst_age_valid", u_age_valid_o, 0);
    chk("rst_age_msb", u_age_msb_o, 1);
    chk("rst_use_alt", use_alt_on_na_o, 1);
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.taken = 1'($urandom_range(0, 1));
    r.pred  = 1'($urandom_range(0, 1));
    r.alt   = 1'($urandom_range(0, 1));
    r.prov  = PW'($urandom_range(0, NTables));
    r.ctr   = CtrBits'($urandom_range(0, (1 << CtrBits) - 1));
    for (int j = 0; j < NTables; j++) r.u[j*UBits +: UBits] = UBits'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic rec_t mk(input logic t, input logic p, input logic a,
                              input int prov, input int ctr, input logic [UW-1:0] u);
    rec_t r;
    r.taken = t;
    r.pred  = p;
    r.alt   = a;
    r.prov  = PW'(prov);
    r.ctr   = CtrBits'(ctr);
    r.u     = u;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  vec_t tbl[8];
  rec_t r;

  task automatic set_vec(input int i, input rec_t rr, input logic pv, input int pctr,
                         input logic inc, input logic dec, input logic av, input int at,
                         input int ac, input logic [NTables-1:0] mask);
    tbl[i].r    = rr;
    tbl[i].pv   = pv;
    tbl[i].pctr = CtrBits'(pctr);
    tbl[i].inc  = inc;
    tbl[i].dec  = dec;
    tbl[i].av   = av;
    tbl[i].at   = PW'(at);
    tbl[i].ac   = CtrBits'(ac);
    tbl[i].mask = mask;
  endtask

  initial begin
    // u vectors are {u6,u5,u4,u3,u2,u1}, two bits each.
    // 0: no free entry above p=2 -> decay tables 3..6
    set_vec(0, mk(1, 0, 0, 2, 4, 12'b01_01_01_01_01_01), 1, 5, 0, 0, 0, 0, 0, 6'b111100);
    // 1: u3=1, u4..u6=0, LFSR bit 0 is 0 here -> lowest candidate, table 4
    set_vec(1, mk(1, 0, 0, 2, 4, 12'b00_00_00_01_01_01), 1, 5, 0, 0, 1, 4, 4, 6'b000000);
    // 2: saturate high, provider right and alt wrong
    set_vec(2, mk(1, 1, 0, 3, 7, 12'b01_01_01_01_01_01), 1, 7, 1, 0, 0, 0, 0, 6'b000000);
    // 3: saturate low
    set_vec(3, mk(0, 0, 0, 3, 0, 12'b01_01_01_01_01_01), 1, 0, 0, 0, 0, 0, 0, 6'b000000);
    // 4: base provider mispredicts, only table 5 free, not-taken init
    set_vec(4, mk(0, 1, 0, 0, 5, 12'b01_00_01_01_01_01), 0, 0, 0, 0, 1, 5, 3, 6'b000000);
    // 5: top table mispredicts: no allocation, no decay, u decrement
    set_vec(5, mk(1, 0, 1, 6, 3, 12'b00_00_00_00_00_00), 1, 4, 0, 1, 0, 0, 0, 6'b000000);
    // 6: p=1 mispredicts, nothing free -> decay tables 2..6
    set_vec(6, mk(0, 1, 1, 1, 4, 12'b01_01_01_01_01_01), 1, 3, 0, 0, 0, 0, 0, 6'b111110);
    // 7: correct provider disagreeing with alt -> u increment
    set_vec(7, mk(1, 1, 0, 4, 2, 12'b01_01_01_01_01_01), 1, 3, 1, 0, 0, 0, 0, 6'b000000);

    upd_valid_i = 1'b0; upd_taken_i = 1'b0; upd_pred_i = 1'b0; upd_alt_pred_i = 1'b0;
    upd_provider_i = '0; upd_prov_ctr_i = '0; upd_u_i = '0;
    @(negedge clk);

    // Reset values
    do_reset();
    check_reset_values();

    // Vector table, back to back straight after reset
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].r);
      chk($sformatf("vec%0d_prov_valid", i), prov_upd_valid_o, tbl[i].pv);
      if (tbl[i].pv) chk($sformatf("vec%0d_prov_ctr", i), prov_ctr_o, tbl[i].pctr);
      chk($sformatf("vec%0d_u_inc", i), prov_u_inc_o, tbl[i].inc);
      chk($sformatf("vec%0d_u_dec", i), prov_u_dec_o, tbl[i].dec);
      chk($sformatf("vec%0d_alloc_valid", i), alloc_valid_o, tbl[i].av);
      if (tbl[i].av) begin
        chk($sformatf("vec%0d_alloc_table", i), alloc_table_o, tbl[i].at);
        chk($sformatf("vec%0d_alloc_ctr", i), alloc_ctr_o, tbl[i].ac);
      end
      chk($sformatf("vec%0d_dec_mask", i), dec_u_mask_o, tbl[i].mask);
    end
    step(1'b0, tbl[0].r);

    // Use-alt-on-NA: 9 records with alt right, then 8 with alt wrong
    check_cycle();
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, mk(1, 0, 1, 1, 3, 12'b01_01_01_01_01_01));
    chk("use_alt_sat_high", use_alt_on_na_o, 1);
    for (int i = 0; i < 8; i++) step(1'b1, mk(1, 1, 0, 1, 3, 12'b01_01_01_01_01_01));
    chk("use_alt_after_dec", use_alt_on_na_o, 0);

    // Aging: first pulse after 1024 records, then 2048 more
    check_cycle();
    do_reset();
    for (int i = 0; i < InitialRstCtr; i++) step(1'b1, rand_rec());
    chk("age1_valid", u_age_valid_o, 1);
    chk("age1_msb", u_age_msb_o, 1);
    chk("age1_ready", upd_ready_o, 0);
    m_acc = 0;
    for (int i = 0; i < UResetPeriod + 50 && m_acc < UResetPeriod; i++) step(1'b1, rand_rec());
    chk("age2_records", m_acc, UResetPeriod);
    chk("age2_valid", u_age_valid_o, 1);
    chk("age2_msb", u_age_msb_o, 0);
    chk("age2_ready", upd_ready_o, 0);

    // Reset while in AGE: no further pulse, counters back to initial values
    check_cycle();
    do_reset();
    check_reset_values();
    for (int i = 0; i < 20; i++) step(1'b1, rand_rec());

    // Random traffic with gaps
    for (int i = 0; i < 400; i++) begin
      r = rand_rec();
      step(($urandom_range(0, 3) != 0), r);
    end
    check_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
